axi4_lite_interconnect_m1sn: RTL and testbench

//  Parametrised 1-master / N-slave AXI4-Lite interconnect; successor of the fixed 1x2 crossbar.

---
 rtl/axi4_lite_interconnect_m1sn.sv | 224 ++++++++++++++++++++++
 tb/tb_axi4_lite_interconnect_m1sn.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_interconnect_m1sn.sv
// 1-master / N-slave AXI4-Lite interconnect.
// Each master transaction is decoded against an inclusive [low, high] address
// window per slave and routed to that slave. Addresses outside every window are
// answered locally with DECERR. The write and read paths are independent, and
// each path has at most one transaction in flight.
//
// Write FSM
//   state     | meaning
//   WR_IDLE   | accepting AW, latch address and target slave
//   WR_ADDR   | presenting AW to the selected slave
//   WR_DATA   | passing W between master and the selected slave
//   WR_RESP   | passing B from the selected slave back to the master
//   WR_DERR_W | unmapped write, swallowing the W beat
//   WR_DERR_B | unmapped write, returning DECERR on B
// Read FSM
//   state     | meaning
//   RD_IDLE   | accepting AR, latch address and target slave
//   RD_ADDR   | presenting AR to the selected slave
//   RD_DATA   | passing R from the selected slave back to the master
//   RD_DERR   | unmapped read, returning zero data with DECERR
module axi4_lite_interconnect_m1sn #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] ADDR_LOW  = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] ADDR_HIGH = '0
) (
    input  logic                             iCLK,
    input  logic                             iRST,
    input  logic                             m_AWVALID,
    input  logic [ADDR_WIDTH-1:0]            m_AWADDR,
    output logic                             m_AWREADY,
    input  logic                             m_WVALID,
    input  logic [DATA_WIDTH-1:0]            m_WDATA,
    input  logic [DATA_WIDTH/8-1:0]          m_WSTRB,
    output logic                             m_WREADY,
    output logic                             m_BVALID,
    output logic [1:0]                       m_BRESP,
    input  logic                             m_BREADY,
    input  logic                             m_ARVALID,
    input  logic [ADDR_WIDTH-1:0]            m_ARADDR,
    output logic                             m_ARREADY,
    output logic                             m_RVALID,
    output logic [DATA_WIDTH-1:0]            m_RDATA,
    output logic [1:0]                       m_RRESP,
    input  logic                             m_RREADY,
    output logic [NUM_SLAVES-1:0]            s_AWVALID,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_AWADDR,
    input  logic [NUM_SLAVES-1:0]            s_AWREADY,
    output logic [NUM_SLAVES-1:0]            s_WVALID,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0] s_WDATA,
    output logic [NUM_SLAVES*DATA_WIDTH/8-1:0] s_WSTRB,
    input  logic [NUM_SLAVES-1:0]            s_WREADY,
    input  logic [NUM_SLAVES-1:0]            s_BVALID,
    input  logic [NUM_SLAVES*2-1:0]          s_BRESP,
    output logic [NUM_SLAVES-1:0]            s_BREADY,
    output logic [NUM_SLAVES-1:0]            s_ARVALID,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_ARADDR,
    input  logic [NUM_SLAVES-1:0]            s_ARREADY,
    input  logic [NUM_SLAVES-1:0]            s_RVALID,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_RDATA,
    input  logic [NUM_SLAVES*2-1:0]          s_RRESP,
    output logic [NUM_SLAVES-1:0]            s_RREADY
);

    localparam int SEL_WIDTH = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        WR_IDLE, WR_ADDR, WR_DATA, WR_RESP, WR_DERR_W, WR_DERR_B
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE, RD_ADDR, RD_DATA, RD_DERR
    } rd_state_t;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;
    logic [SEL_WIDTH-1:0]  wr_sel, rd_sel;
    logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
    logic [SEL_WIDTH:0]    aw_dec, ar_dec;

    // Returns {hit, index}. Scanning from the top down lets the lowest index win
    // on overlapping windows. The window test is written as an offset compare so
    // a zero base does not turn into a degenerate "addr >= 0" comparison.
    function automatic logic [SEL_WIDTH:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [SEL_WIDTH:0]  res;
        logic [ADDR_WIDTH-1:0] lo, hi;
        res = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            lo = ADDR_LOW[k*ADDR_WIDTH +: ADDR_WIDTH];
            hi = ADDR_HIGH[k*ADDR_WIDTH +: ADDR_WIDTH];
            if ((lo <= hi) && ((addr - lo) <= (hi - lo)))
                res = {1'b1, SEL_WIDTH'(k)};
        end
        return res;
    endfunction

    assign aw_dec = decode(m_AWADDR);
    assign ar_dec = decode(m_ARADDR);

    assign s_AWADDR = {NUM_SLAVES{awaddr_q}};
    assign s_ARADDR = {NUM_SLAVES{araddr_q}};
    assign s_WDATA  = {NUM_SLAVES{m_WDATA}};
    assign s_WSTRB  = {NUM_SLAVES{m_WSTRB}};

    // Write path state, latched address and target slave.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wr_state <= WR_IDLE;
            wr_sel   <= '0;
            awaddr_q <= '0;
        end else begin
            wr_state <= wr_next;
            if (wr_state == WR_IDLE && m_AWVALID) begin
                awaddr_q <= m_AWADDR;
                wr_sel   <= aw_dec[SEL_WIDTH-1:0];
            end
        end
    end

    // Write path next state and routing; READY is held low while reset is applied.
    always_comb begin
        wr_next   = wr_state;
        m_AWREADY = 1'b0;
        m_WREADY  = 1'b0;
        m_BVALID  = 1'b0;
        m_BRESP   = 2'b00;
        s_AWVALID = '0;
        s_WVALID  = '0;
        s_BREADY  = '0;
        case (wr_state)
            WR_IDLE: begin
                m_AWREADY = !iRST;
                if (m_AWVALID)
                    wr_next = aw_dec[SEL_WIDTH] ? WR_ADDR : WR_DERR_W;
            end
            WR_ADDR: begin
                s_AWVALID[wr_sel] = 1'b1;
                if (s_AWREADY[wr_sel])
                    wr_next = WR_DATA;
            end
            WR_DATA: begin
                s_WVALID[wr_sel] = m_WVALID;
                m_WREADY         = s_WREADY[wr_sel];
                if (m_WVALID && s_WREADY[wr_sel])
                    wr_next = WR_RESP;
            end
            WR_RESP: begin
                m_BVALID         = s_BVALID[wr_sel];
                m_BRESP          = s_BRESP[2*wr_sel +: 2];
                s_BREADY[wr_sel] = m_BREADY;
                if (s_BVALID[wr_sel] && m_BREADY)
                    wr_next = WR_IDLE;
            end
            WR_DERR_W: begin
                m_WREADY = 1'b1;
                if (m_WVALID)
                    wr_next = WR_DERR_B;
            end
            WR_DERR_B: begin
                m_BVALID = 1'b1;
                m_BRESP  = RESP_DECERR;
                if (m_BREADY)
                    wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    // Read path state, latched address and target slave.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rd_state <= RD_IDLE;
            rd_sel   <= '0;
            araddr_q <= '0;
        end else begin
            rd_state <= rd_next;
            if (rd_state == RD_IDLE && m_ARVALID) begin
                araddr_q <= m_ARADDR;
                rd_sel   <= ar_dec[SEL_WIDTH-1:0];
            end
        end
    end

    // Read path next state and routing; READY is held low while reset is applied.
    always_comb begin
        rd_next   = rd_state;
        m_ARREADY = 1'b0;
        m_RVALID  = 1'b0;
        m_RDATA   = '0;
        m_RRESP   = 2'b00;
        s_ARVALID = '0;
        s_RREADY  = '0;
        case (rd_state)
            RD_IDLE: begin
                m_ARREADY = !iRST;
                if (m_ARVALID)
                    rd_next = ar_dec[SEL_WIDTH] ? RD_ADDR : RD_DERR;
            end
            RD_ADDR: begin
                s_ARVALID[rd_sel] = 1'b1;
                if (s_ARREADY[rd_sel])
                    rd_next = RD_DATA;
            end
            RD_DATA: begin
                m_RVALID         = s_RVALID[rd_sel];
                m_RDATA          = s_RDATA[DATA_WIDTH*rd_sel +: DATA_WIDTH];
                m_RRESP          = s_RRESP[2*rd_sel +: 2];
                s_RREADY[rd_sel] = m_RREADY;
                if (s_RVALID[rd_sel] && m_RREADY)
                    rd_next = RD_IDLE;
            end
            RD_DERR: begin
                m_RVALID = 1'b1;
                m_RRESP  = RESP_DECERR;
                if (m_RREADY)
                    rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_interconnect_m1sn.sv
// Bench for the 1xN AXI4-Lite interconnect: four memory slaves at 0x000-0x3FF,
// directed scenarios followed by randomized traffic against a flat memory model.
module tb_axi4_lite_interconnect_m1sn;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam logic [N*AW-1:0] LOW  = {32'h300, 32'h200, 32'h100, 32'h000};
    localparam logic [N*AW-1:0] HIGH = {32'h3FF, 32'h2FF, 32'h1FF, 32'h0FF};

    logic iCLK = 1'b0;
    logic iRST = 1'b1;

    logic          m_AWVALID = 1'b0, m_WVALID = 1'b0, m_BREADY = 1'b0;
    logic [AW-1:0] m_AWADDR = '0;
    logic [DW-1:0] m_WDATA = '0;
    logic [SW-1:0] m_WSTRB = '0;
    logic          m_ARVALID = 1'b0, m_RREADY = 1'b0;
    logic [AW-1:0] m_ARADDR = '0;
    logic          m_AWREADY, m_WREADY, m_BVALID, m_ARREADY, m_RVALID;
    logic [1:0]    m_BRESP, m_RRESP;
    logic [DW-1:0] m_RDATA;

    logic [N-1:0]    s_AWVALID, s_WVALID, s_BREADY, s_ARVALID, s_RREADY;
    logic [N*AW-1:0] s_AWADDR, s_ARADDR;
    logic [N*DW-1:0] s_WDATA;
    logic [N*SW-1:0] s_WSTRB;
    logic [N-1:0]    s_AWREADY = '0, s_WREADY = '0, s_BVALID = '0;
    logic [N-1:0]    s_ARREADY = '0, s_RVALID = '0;
    logic [N*2-1:0]  s_BRESP = '0, s_RRESP = '0;
    logic [N*DW-1:0] s_RDATA = '0;

    axi4_lite_interconnect_m1sn #(
        .NUM_SLAVES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .ADDR_LOW(LOW), .ADDR_HIGH(HIGH)
    ) dut (
        .iCLK(iCLK), .iRST(iRST),
        .m_AWVALID(m_AWVALID), .m_AWADDR(m_AWADDR), .m_AWREADY(m_AWREADY),
        .m_WVALID(m_WVALID), .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB), .m_WREADY(m_WREADY),
        .m_BVALID(m_BVALID), .m_BRESP(m_BRESP), .m_BREADY(m_BREADY),
        .m_ARVALID(m_ARVALID), .m_ARADDR(m_ARADDR), .m_ARREADY(m_ARREADY),
        .m_RVALID(m_RVALID), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RREADY(m_RREADY),
        .s_AWVALID(s_AWVALID), .s_AWADDR(s_AWADDR), .s_AWREADY(s_AWREADY),
        .s_WVALID(s_WVALID), .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB), .s_WREADY(s_WREADY),
        .s_BVALID(s_BVALID), .s_BRESP(s_BRESP), .s_BREADY(s_BREADY),
        .s_ARVALID(s_ARVALID), .s_ARADDR(s_ARADDR), .s_ARREADY(s_ARREADY),
        .s_RVALID(s_RVALID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RREADY(s_RREADY)
    );

    always #5 iCLK = ~iCLK;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: flat byte-addressed word store plus per-slave traffic counts.
    logic [31:0] exp_mem [int];
    int exp_aw [N];
    int exp_w  [N];
    int exp_ar [N];

    // Slave-side state, owned by the slave responder process.
    logic [31:0] slv_mem [int];
    bit        aw_have [N];
    bit [31:0] aw_addr [N];
    bit        w_have  [N];
    int        b_dly   [N];
    bit        r_have  [N];
    bit [31:0] r_addr  [N];
    int        r_dly   [N];
    int        aw_cnt  [N];
    int        w_cnt   [N];
    int        ar_cnt  [N];
    int        force_bdly = -1;
    bit        w_stall = 1'b0;
    bit        wr_busy = 1'b0;
    bit        rd_busy = 1'b0;
    int        bp_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int slave_of(input logic [31:0] a);
        if (a < 32'h400) return int'(a >> 8);
        return -1;
    endfunction

    function automatic logic [31:0] dflt(input bit [31:0] a);
        return 32'hA5A5_0000 | {16'h0, a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (slave_of(a) < 0) return 32'h0;
        if (exp_mem.exists(int'(a))) return exp_mem[int'(a)];
        return dflt(a);
    endfunction

    function automatic logic [31:0] slv_read(input int k, input bit [31:0] a);
        int key;
        key = k * 65536 + int'(a[15:0]);
        if (slv_mem.exists(key)) return slv_mem[key];
        return dflt(a);
    endfunction

    // Slave responders drive at the falling edge; handshakes and protocol-level
    // invariants are observed just before the next rising edge.
    always @(negedge iCLK) begin
        for (int k = 0; k < N; k++) begin
            s_AWREADY[k] = !aw_have[k] && ($urandom_range(0, 3) != 0);
            s_WREADY[k]  = aw_have[k] && !w_have[k] && !w_stall && ($urandom_range(0, 3) != 0);
            s_BVALID[k]  = w_have[k] && (b_dly[k] == 0);
            s_BRESP[2*k +: 2] = 2'b00;
            s_ARREADY[k] = !r_have[k] && ($urandom_range(0, 3) != 0);
            s_RVALID[k]  = r_have[k] && (r_dly[k] == 0);
            s_RDATA[DW*k +: DW] = r_have[k] ? slv_read(k, r_addr[k]) : 32'h0;
            s_RRESP[2*k +: 2] = 2'b00;
        end
        #3;
        if (iRST) begin
            wr_busy = 1'b0;
            rd_busy = 1'b0;
            for (int k = 0; k < N; k++) begin
                aw_have[k] = 1'b0; w_have[k] = 1'b0; r_have[k] = 1'b0;
                b_dly[k] = 0; r_dly[k] = 0;
            end
        end else begin
            if (wr_busy == m_AWREADY) bp_err++;
            if (rd_busy == m_ARREADY) bp_err++;
            if (!wr_busy && (m_BVALID || m_WREADY || (|s_AWVALID) || (|s_WVALID) || (|s_BREADY))) bp_err++;
            if (!rd_busy && (m_RVALID || (|s_ARVALID) || (|s_RREADY))) bp_err++;
            if ($countones(s_AWVALID | s_WVALID | s_BREADY) > 1) bp_err++;
            if ($countones(s_ARVALID | s_RREADY) > 1) bp_err++;
            if (m_AWVALID && m_AWREADY) wr_busy = 1'b1;
            if (m_BVALID && m_BREADY)   wr_busy = 1'b0;
            if (m_ARVALID && m_ARREADY) rd_busy = 1'b1;
            if (m_RVALID && m_RREADY)   rd_busy = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (s_AWVALID[k] && s_AWREADY[k]) begin
                    aw_have[k] = 1'b1;
                    aw_addr[k] = s_AWADDR[AW*k +: AW];
                    aw_cnt[k]++;
                end
                if (s_WVALID[k] && s_WREADY[k]) begin
                    slv_mem[k * 65536 + int'(aw_addr[k][15:0])] =
                        merge(slv_read(k, aw_addr[k]), s_WDATA[DW*k +: DW], s_WSTRB[SW*k +: SW]);
                    w_have[k] = 1'b1;
                    b_dly[k]  = (force_bdly >= 0) ? force_bdly : int'($urandom_range(0, 2));
                    w_cnt[k]++;
                end else if (w_have[k] && b_dly[k] > 0) begin
                    b_dly[k]--;
                end
                if (s_BVALID[k] && s_BREADY[k]) begin
                    aw_have[k] = 1'b0;
                    w_have[k]  = 1'b0;
                end
                if (s_ARVALID[k] && s_ARREADY[k]) begin
                    r_have[k] = 1'b1;
                    r_addr[k] = s_ARADDR[AW*k +: AW];
                    r_dly[k]  = int'($urandom_range(0, 2));
                    ar_cnt[k]++;
                end else if (r_have[k] && r_dly[k] > 0) begin
                    r_dly[k]--;
                end
                if (s_RVALID[k] && s_RREADY[k]) r_have[k] = 1'b0;
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output bit ok);
        bit aw_hs, w_hs, b_hs;
        int cyc;
        aw_hs = 1'b0; w_hs = 1'b0; b_hs = 1'b0; cyc = 0; resp = 2'b00;
        @(negedge iCLK);
        m_AWVALID = 1'b1; m_AWADDR = a;
        m_WVALID = 1'b1; m_WDATA = d; m_WSTRB = s;
        m_BREADY = ($urandom_range(0, 1) == 1);
        while (!b_hs && cyc < 200) begin
            #3;
            if (m_AWVALID && m_AWREADY) aw_hs = 1'b1;
            if (m_WVALID && m_WREADY) w_hs = 1'b1;
            if (m_BVALID && m_BREADY) begin
                b_hs = 1'b1;
                resp = m_BRESP;
            end
            @(negedge iCLK);
            if (aw_hs) m_AWVALID = 1'b0;
            if (w_hs) m_WVALID = 1'b0;
            m_BREADY = !b_hs && ((cyc > 3) || ($urandom_range(0, 1) == 1));
            cyc++;
        end
        m_AWVALID = 1'b0; m_WVALID = 1'b0; m_BREADY = 1'b0;
        ok = b_hs;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output bit ok);
        bit ar_hs, r_hs;
        int cyc;
        ar_hs = 1'b0; r_hs = 1'b0; cyc = 0; d = '0; resp = 2'b00;
        @(negedge iCLK);
        m_ARVALID = 1'b1; m_ARADDR = a;
        m_RREADY = ($urandom_range(0, 1) == 1);
        while (!r_hs && cyc < 200) begin
            #3;
            if (m_ARVALID && m_ARREADY) ar_hs = 1'b1;
            if (m_RVALID && m_RREADY) begin
                r_hs = 1'b1;
                d    = m_RDATA;
                resp = m_RRESP;
            end
            @(negedge iCLK);
            if (ar_hs) m_ARVALID = 1'b0;
            m_RREADY = !r_hs && ((cyc > 3) || ($urandom_range(0, 1) == 1));
            cyc++;
        end
        m_ARVALID = 1'b0; m_RREADY = 1'b0;
        ok = r_hs;
    endtask

    task automatic wr_chk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input string tag);
        logic [1:0] r;
        bit ok;
        int k;
        do_write(a, d, s, r, ok);
        check({tag, "_wr_done"}, 64'(ok), 64'd1);
        k = slave_of(a);
        if (k >= 0) begin
            exp_mem[int'(a)] = merge(exp_rd(a), d, s);
            exp_aw[k]++;
            exp_w[k]++;
        end
        check({tag, "_bresp"}, 64'(r), (k >= 0) ? 64'd0 : 64'd3);
    endtask

    task automatic rd_chk(input logic [31:0] a, input string tag);
        logic [31:0] d, e;
        logic [1:0] r;
        bit ok;
        int k;
        e = exp_rd(a);
        k = slave_of(a);
        do_read(a, d, r, ok);
        check({tag, "_rd_done"}, 64'(ok), 64'd1);
        if (k >= 0) exp_ar[k]++;
        check({tag, "_rdata"}, 64'(d), 64'(e));
        check({tag, "_rresp"}, 64'(r), (k >= 0) ? 64'd0 : 64'd3);
    endtask

    task automatic check_counts(input string tag);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_aw_cnt%0d", tag, k), 64'(aw_cnt[k]), 64'(exp_aw[k]));
            check($sformatf("%s_w_cnt%0d", tag, k), 64'(w_cnt[k]), 64'(exp_w[k]));
            check($sformatf("%s_ar_cnt%0d", tag, k), 64'(ar_cnt[k]), 64'(exp_ar[k]));
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid_ready"},
              64'({m_AWREADY, m_WREADY, m_BVALID, m_ARREADY, m_RVALID,
                   s_AWVALID, s_WVALID, s_BREADY, s_ARVALID, s_RREADY}), 64'd0);
        check({tag, "_s_awaddr"}, 64'(|s_AWADDR), 64'd0);
        check({tag, "_s_araddr"}, 64'(|s_ARADDR), 64'd0);
        check({tag, "_resp"}, 64'({m_BRESP, m_RRESP}), 64'd0);
        check({tag, "_rdata"}, 64'(m_RDATA), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, a2, d;
        logic [3:0]  s;
        logic [31:0] bound [8];
        int mode, cyc;
        bit hs;

        repeat (3) @(negedge iCLK);
        #3;
        check_quiet("reset");
        @(negedge iCLK);
        iRST = 1'b0;

        wr_chk(32'h204, 32'hDEADBEEF, 4'hF, "w204");
        rd_chk(32'h204, "r204");
        check_counts("slave2_write");

        force_bdly = 5;
        wr_chk(32'h104, 32'h12345678, 4'hF, "w104_bstall");
        check("bstall_backpressure", 64'(bp_err), 64'd0);
        force_bdly = -1;
        rd_chk(32'h104, "r104");
        check_counts("slave1_rw");

        wr_chk(32'h400, 32'h0BADF00D, 4'hF, "w400");
        rd_chk(32'h400, "r400");
        check_counts("decerr");

        fork
            wr_chk(32'h010, 32'hA1B2C3D4, 4'hF, "w010_par");
            rd_chk(32'h310, "r310_par");
        join
        check_counts("parallel");

        bound = '{32'h0FF, 32'h100, 32'h1FF, 32'h2FF, 32'h300, 32'h3FF, 32'h400, 32'hFFFF_FFFF};
        for (int i = 0; i < 8; i++) begin
            wr_chk(bound[i], $urandom, 4'($urandom_range(1, 15)), $sformatf("bnd_w%0d", i));
            rd_chk(bound[i], $sformatf("bnd_r%0d", i));
        end
        check_counts("boundary");

        w_stall = 1'b1;
        exp_aw[1]++;
        @(negedge iCLK);
        m_AWVALID = 1'b1; m_AWADDR = 32'h108;
        m_WVALID = 1'b1; m_WDATA = 32'hCAFEF00D; m_WSTRB = 4'hF; m_BREADY = 1'b1;
        hs = 1'b0; cyc = 0;
        while (!hs && cyc < 50) begin
            #3;
            if (m_AWREADY) hs = 1'b1;
            @(negedge iCLK);
            cyc++;
        end
        m_AWVALID = 1'b0;
        check("rst_aw_accept", 64'(hs), 64'd1);
        cyc = 0;
        while (aw_cnt[1] != exp_aw[1] && cyc < 50) begin
            @(negedge iCLK);
            cyc++;
        end
        check("rst_slave1_aw", 64'(aw_cnt[1]), 64'(exp_aw[1]));
        @(negedge iCLK);
        #3;
        check("rst_in_wr_data_wvalid", 64'(s_WVALID), 64'b0010);
        check("rst_in_wr_data_wready", 64'(m_WREADY), 64'd0);
        @(negedge iCLK);
        iRST = 1'b1;
        w_stall = 1'b0;
        m_WVALID = 1'b0; m_BREADY = 1'b0;
        @(negedge iCLK);
        #3;
        check_quiet("mid_reset");
        @(negedge iCLK);
        iRST = 1'b0;
        wr_chk(32'h0FC, 32'h55AA1234, 4'hF, "w0fc_after_rst");
        rd_chk(32'h0FC, "r0fc_after_rst");
        rd_chk(32'h108, "r108_aborted");
        check_counts("after_reset");

        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 2));
            a  = (32'($urandom_range(0, 4)) << 8) | (32'($urandom_range(0, 7)) << 2);
            a2 = (32'($urandom_range(0, 4)) << 8) | (32'($urandom_range(0, 7)) << 2);
            if (a2 == a) a2 = a ^ 32'h4;
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            case (mode)
                0: wr_chk(a, d, s, $sformatf("rnd%0d", i));
                1: rd_chk(a, $sformatf("rnd%0d", i));
                default: begin
                    fork
                        wr_chk(a, d, s, $sformatf("rnd%0d_par", i));
                        rd_chk(a2, $sformatf("rnd%0d_par", i));
                    join
                end
            endcase
        end
        check_counts("random");
        check("protocol_monitor", 64'(bp_err), 64'd0);

        repeat (2) @(negedge iCLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
